// File: rtl/rename_if.sv
// rename_if: rename-controller bus bundling rename, completion, retire and RAT ports.
// master: rename/CDB/retire requester plus RAT outputs (rat_assignments, rat_done).
// slave : rename_ctrl, drives ren_ready/ren_pr/ren_old_pr, RAT next-state and free_count.
interface rename_if #(
    parameter int NUM_LRS    = 10,
    parameter int ADDR_WIDTH = 5,
    parameter int LR_WIDTH   = 4
);
    logic                          ren_valid;
    logic [LR_WIDTH-1:0]           ren_lr;
    logic                          ren_ready;
    logic [ADDR_WIDTH-1:0]         ren_pr;
    logic [ADDR_WIDTH-1:0]         ren_old_pr;
    logic                          cdb_valid;
    logic [ADDR_WIDTH-1:0]         cdb_pr;
    logic                          free_valid;
    logic [ADDR_WIDTH-1:0]         free_pr;
    logic [NUM_LRS*ADDR_WIDTH-1:0] rat_assignments;
    logic [NUM_LRS-1:0]            rat_done;
    logic [NUM_LRS*ADDR_WIDTH-1:0] assignments_in;
    logic [NUM_LRS-1:0]            done_flags_in;
    logic [ADDR_WIDTH:0]           free_count;

    modport master (
        output ren_valid, ren_lr, cdb_valid, cdb_pr, free_valid, free_pr, rat_assignments, rat_done,
        input  ren_ready, ren_pr, ren_old_pr, assignments_in, done_flags_in, free_count
    );
    modport slave (
        input  ren_valid, ren_lr, cdb_valid, cdb_pr, free_valid, free_pr, rat_assignments, rat_done,
        output ren_ready, ren_pr, ren_old_pr, assignments_in, done_flags_in, free_count
    );
endinterface

// File: rtl/rename_ctrl.sv
// rename_ctrl: free-list owner and RAT next-state sequencer for the OoO 6502 core.
// Ports: clk, rst (sync, active-high), bus (rename_if.slave): rename request/grant,
// CDB completion, retire free, RAT current state in, RAT next state out, free_count.
// Option: define RENAME_FREE_BYPASS_EN to let a rename take the retiring PR when the list is empty.
module rename_ctrl #(
    parameter int NUM_LRS    = 10,
    parameter int ADDR_WIDTH = 5,
    parameter int LR_WIDTH   = 4
) (
    input logic     clk,
    input logic     rst,
    rename_if.slave bus
);
    localparam int NUM_PRS = 1 << ADDR_WIDTH;

    typedef enum logic {INIT, RUN} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] mem [NUM_PRS];
    logic [ADDR_WIDTH-1:0] head, tail, new_pr;
    logic [ADDR_WIDTH:0]   count;
    logic                  run, lr_ok, bypass, ready, accept, push, pop;

    always_ff @(posedge clk)
        state <= rst ? INIT : state_nxt;

    always_comb
        state_nxt = RUN;

    // rst is folded in so INIT values appear while rst is still high
    assign run   = !rst && state == RUN;
    assign lr_ok = int'(bus.ren_lr) < NUM_LRS;
`ifdef RENAME_FREE_BYPASS_EN
    assign bypass = run && count == '0 && bus.free_valid;
`else
    assign bypass = 1'b0;
`endif
    assign ready  = run && lr_ok && (count != '0 || bypass);
    assign accept = bus.ren_valid && ready;
    assign new_pr = bypass ? bus.free_pr : mem[head];
    assign pop    = accept && !bypass;
    // a bypassed rename consumes the retiring PR, so nothing is pushed
    assign push   = run && bus.free_valid && !(accept && bypass) && count != (ADDR_WIDTH+1)'(NUM_PRS);

    always_comb begin
        bus.ren_ready      = ready;
        bus.ren_pr         = new_pr;
        bus.free_count     = count;
        bus.ren_old_pr     = '0;
        bus.assignments_in = bus.rat_assignments;
        bus.done_flags_in  = bus.rat_done;
        for (int i = 0; i < NUM_LRS; i++) begin
            if (bus.ren_lr == LR_WIDTH'(i))
                bus.ren_old_pr = bus.rat_assignments[i*ADDR_WIDTH +: ADDR_WIDTH];
            if (!run) begin
                bus.assignments_in[i*ADDR_WIDTH +: ADDR_WIDTH] = ADDR_WIDTH'(i);
                bus.done_flags_in[i] = 1'b1;
            end else begin
                if (bus.cdb_valid && bus.rat_assignments[i*ADDR_WIDTH +: ADDR_WIDTH] == bus.cdb_pr)
                    bus.done_flags_in[i] = 1'b1;
                // rename after completion so a same-LR collision leaves the bit cleared
                if (accept && bus.ren_lr == LR_WIDTH'(i)) begin
                    bus.assignments_in[i*ADDR_WIDTH +: ADDR_WIDTH] = new_pr;
                    bus.done_flags_in[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_PRS; i++)
                mem[i] <= ADDR_WIDTH'(i + NUM_LRS);
            head  <= '0;
            tail  <= ADDR_WIDTH'(NUM_PRS - NUM_LRS);
            count <= (ADDR_WIDTH+1)'(NUM_PRS - NUM_LRS);
        end else begin
            if (push) begin
                mem[tail] <= bus.free_pr;
                tail      <= tail + 1'b1;
            end
            if (pop)
                head <= head + 1'b1;
            count <= count + (ADDR_WIDTH+1)'(push) - (ADDR_WIDTH+1)'(pop);
        end
    end
endmodule

// File: tb/tb_rename_ctrl.sv
// tb_rename_ctrl: directed self-checking bench for rename_ctrl with a registered RAT model.
module tb_rename_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic [49:0] ident;

    rename_if #(.NUM_LRS(10), .ADDR_WIDTH(5), .LR_WIDTH(4)) bus();

    rename_ctrl #(.NUM_LRS(10), .ADDR_WIDTH(5), .LR_WIDTH(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        bus.rat_assignments <= bus.assignments_in;
        bus.rat_done        <= bus.done_flags_in;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.ren_valid  = 1'b0;
        bus.ren_lr     = '0;
        bus.cdb_valid  = 1'b0;
        bus.cdb_pr     = '0;
        bus.free_valid = 1'b0;
        bus.free_pr    = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic drain(input logic [3:0] lr);
        bus.ren_valid = 1'b1;
        bus.ren_lr    = lr;
        repeat (22) tick();
        bus.ren_valid = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.ren_ready !== 1'b0 || bus.free_count !== 6'd22) begin
            errors++;
            $display("FAIL reset_out: ready=%b count=%0d expected ready=0 count=22", bus.ren_ready, bus.free_count);
        end
        checks++;
        if (bus.assignments_in !== ident || bus.done_flags_in !== 10'h3FF) begin
            errors++;
            $display("FAIL reset_init: asg=%h done=%h expected asg=%h done=3ff", bus.assignments_in, bus.done_flags_in, ident);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.ren_ready !== 1'b0 || bus.assignments_in !== ident || bus.done_flags_in !== 10'h3FF) begin
            errors++;
            $display("FAIL init_state: ready=%b asg=%h done=%h expected ready=0 asg=%h done=3ff", bus.ren_ready, bus.assignments_in, bus.done_flags_in, ident);
        end
        tick();
        checks++;
        if (bus.rat_assignments !== ident || bus.rat_done !== 10'h3FF || bus.ren_ready !== 1'b1) begin
            errors++;
            $display("FAIL run_entry: rat=%h done=%h ready=%b expected rat=%h done=3ff ready=1", bus.rat_assignments, bus.rat_done, bus.ren_ready, ident);
        end
    endtask

    task automatic test_alloc_sequence();
        bus.ren_valid = 1'b1;
        bus.ren_lr    = 4'd3;
        for (int k = 0; k < 22; k++) begin
            #1;
            checks++;
            if (bus.ren_ready !== 1'b1 || bus.ren_pr !== 5'(10 + k) || bus.ren_old_pr !== (k == 0 ? 5'd3 : 5'(9 + k))) begin
                errors++;
                $display("FAIL alloc_%0d: ready=%b pr=%0d old=%0d expected ready=1 pr=%0d old=%0d", k, bus.ren_ready, bus.ren_pr, bus.ren_old_pr, 10 + k, k == 0 ? 3 : 9 + k);
            end
            tick();
        end
        #1;
        checks++;
        if (bus.ren_ready !== 1'b0 || bus.free_count !== 6'd0) begin
            errors++;
            $display("FAIL alloc_empty: ready=%b count=%0d expected ready=0 count=0", bus.ren_ready, bus.free_count);
        end
        bus.ren_valid = 1'b0;
    endtask

    task automatic test_rename_cdb();
        do_reset();
        bus.ren_valid = 1'b1;
        bus.ren_lr    = 4'd2;
        #1;
        checks++;
        if (bus.ren_pr !== 5'd10 || bus.ren_old_pr !== 5'd2) begin
            errors++;
            $display("FAIL rename_lr2: pr=%0d old=%0d expected pr=10 old=2", bus.ren_pr, bus.ren_old_pr);
        end
        tick();
        bus.ren_valid = 1'b0;
        #1;
        checks++;
        if (bus.rat_assignments[10 +: 5] !== 5'd10 || bus.rat_done !== 10'h3FB) begin
            errors++;
            $display("FAIL rat_after_rename: slot2=%0d done=%h expected slot2=10 done=3fb", bus.rat_assignments[10 +: 5], bus.rat_done);
        end
        bus.cdb_valid = 1'b1;
        bus.cdb_pr    = 5'd10;
        tick();
        bus.cdb_valid = 1'b0;
        #1;
        checks++;
        if (bus.rat_done !== 10'h3FF) begin
            errors++;
            $display("FAIL cdb_done: done=%h expected 3ff", bus.rat_done);
        end
    endtask

    task automatic test_same_lr();
        bus.ren_valid = 1'b1;
        bus.ren_lr    = 4'd5;
        bus.cdb_valid = 1'b1;
        bus.cdb_pr    = 5'd5;
        #1;
        checks++;
        if (bus.ren_pr !== 5'd11 || bus.done_flags_in[5] !== 1'b0) begin
            errors++;
            $display("FAIL same_lr_comb: pr=%0d done5=%b expected pr=11 done5=0", bus.ren_pr, bus.done_flags_in[5]);
        end
        tick();
        idle();
        #1;
        checks++;
        if (bus.rat_assignments[25 +: 5] !== 5'd11 || bus.rat_done !== 10'h3DF) begin
            errors++;
            $display("FAIL same_lr_rat: slot5=%0d done=%h expected slot5=11 done=3df", bus.rat_assignments[25 +: 5], bus.rat_done);
        end
    endtask

    task automatic test_free_push();
        do_reset();
        drain(4'd0);
        #1;
        checks++;
        if (bus.free_count !== 6'd0) begin
            errors++;
            $display("FAIL drained: count=%0d expected 0", bus.free_count);
        end
        bus.free_valid = 1'b1;
        bus.free_pr    = 5'd7;
        tick();
        bus.free_valid = 1'b0;
        #1;
        checks++;
        if (bus.free_count !== 6'd1) begin
            errors++;
            $display("FAIL push_count: count=%0d expected 1", bus.free_count);
        end
        bus.ren_valid = 1'b1;
        bus.ren_lr    = 4'd1;
        #1;
        checks++;
        if (bus.ren_ready !== 1'b1 || bus.ren_pr !== 5'd7) begin
            errors++;
            $display("FAIL realloc: ready=%b pr=%0d expected ready=1 pr=7", bus.ren_ready, bus.ren_pr);
        end
        tick();
        bus.ren_valid  = 1'b0;
        bus.free_valid = 1'b1;
        bus.free_pr    = 5'd8;
        tick();
        bus.ren_valid = 1'b1;
        bus.free_pr   = 5'd9;
        #1;
        checks++;
        if (bus.ren_pr !== 5'd8 || bus.free_count !== 6'd1) begin
            errors++;
            $display("FAIL pushpop_pre: pr=%0d count=%0d expected pr=8 count=1", bus.ren_pr, bus.free_count);
        end
        tick();
        bus.free_valid = 1'b0;
        #1;
        checks++;
        if (bus.free_count !== 6'd1 || bus.ren_pr !== 5'd9) begin
            errors++;
            $display("FAIL pushpop_post: count=%0d pr=%0d expected count=1 pr=9", bus.free_count, bus.ren_pr);
        end
        bus.ren_valid = 1'b0;
    endtask

    task automatic test_bypass();
        do_reset();
        drain(4'd0);
        bus.ren_valid  = 1'b1;
        bus.ren_lr     = 4'd4;
        bus.free_valid = 1'b1;
        bus.free_pr    = 5'd12;
        #1;
`ifdef RENAME_FREE_BYPASS_EN
        checks++;
        if (bus.ren_ready !== 1'b1 || bus.ren_pr !== 5'd12) begin
            errors++;
            $display("FAIL bypass_grant: ready=%b pr=%0d expected ready=1 pr=12", bus.ren_ready, bus.ren_pr);
        end
        tick();
        idle();
        #1;
        checks++;
        if (bus.free_count !== 6'd0 || bus.rat_assignments[20 +: 5] !== 5'd12) begin
            errors++;
            $display("FAIL bypass_post: count=%0d slot4=%0d expected count=0 slot4=12", bus.free_count, bus.rat_assignments[20 +: 5]);
        end
`else
        checks++;
        if (bus.ren_ready !== 1'b0) begin
            errors++;
            $display("FAIL nobypass_refuse: ready=%b expected 0", bus.ren_ready);
        end
        tick();
        bus.free_valid = 1'b0;
        #1;
        checks++;
        if (bus.free_count !== 6'd1 || bus.ren_ready !== 1'b1 || bus.ren_pr !== 5'd12) begin
            errors++;
            $display("FAIL nobypass_post: count=%0d ready=%b pr=%0d expected count=1 ready=1 pr=12", bus.free_count, bus.ren_ready, bus.ren_pr);
        end
        idle();
`endif
    endtask

    task automatic test_illegal_and_full();
        do_reset();
        bus.ren_valid = 1'b1;
        bus.ren_lr    = 4'd12;
        #1;
        checks++;
        if (bus.ren_ready !== 1'b0) begin
            errors++;
            $display("FAIL illegal_lr: ready=%b expected 0", bus.ren_ready);
        end
        tick();
        bus.ren_valid = 1'b0;
        #1;
        checks++;
        if (bus.free_count !== 6'd22) begin
            errors++;
            $display("FAIL illegal_count: count=%0d expected 22", bus.free_count);
        end
        bus.free_valid = 1'b1;
        for (int k = 0; k < 11; k++) begin
            bus.free_pr = 5'(k);
            tick();
        end
        bus.free_valid = 1'b0;
        #1;
        checks++;
        if (bus.free_count !== 6'd32) begin
            errors++;
            $display("FAIL full_drop: count=%0d expected 32", bus.free_count);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        bus.ren_valid = 1'b1;
        bus.ren_lr    = 4'd6;
        repeat (5) tick();
        bus.ren_valid = 1'b0;
        rst = 1'b1;
        tick();
        checks++;
        if (bus.free_count !== 6'd22 || bus.ren_ready !== 1'b0 || bus.assignments_in !== ident) begin
            errors++;
            $display("FAIL midrst_hold: count=%0d ready=%b asg=%h expected count=22 ready=0 asg=%h", bus.free_count, bus.ren_ready, bus.assignments_in, ident);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.assignments_in !== ident || bus.done_flags_in !== 10'h3FF || bus.ren_ready !== 1'b0) begin
            errors++;
            $display("FAIL midrst_init: asg=%h done=%h ready=%b expected asg=%h done=3ff ready=0", bus.assignments_in, bus.done_flags_in, bus.ren_ready, ident);
        end
        tick();
        bus.ren_valid = 1'b1;
        #1;
        checks++;
        if (bus.rat_assignments !== ident || bus.ren_pr !== 5'd10 || bus.ren_old_pr !== 5'd6) begin
            errors++;
            $display("FAIL midrst_first: rat=%h pr=%0d old=%0d expected rat=%h pr=10 old=6", bus.rat_assignments, bus.ren_pr, bus.ren_old_pr, ident);
        end
        tick();
        bus.ren_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 10; i++)
            ident[i*5 +: 5] = 5'(i);
        test_reset();
        test_alloc_sequence();
        test_rename_cdb();
        test_same_lr();
        test_free_push();
        test_bypass();
        test_illegal_and_full();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
